// File: rtl/acc_pkg.sv
// Shared types and reset constants for the accumulator stage.
package acc_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_LOAD = 2'b10,
    OP_CLR  = 2'b11
  } acc_op_t;

  localparam int   ACC_RST    = 0;
  localparam logic FLAG_Z_RST = 1'b1;

endpackage

// File: rtl/acc_unit_if.sv
// Command/result handshake bundle between a command source and acc_unit.
interface acc_unit_if #(parameter int N = 4);
  import acc_pkg::*;

  logic         in_valid;
  logic         in_ready;
  acc_op_t      in_op;
  logic [N-1:0] in_operand;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] acc;
  logic         flag_c;
  logic         flag_z;
  logic         flag_v;
  logic         ovf_sticky;

  modport master (
    output in_valid, in_op, in_operand, out_ready,
    input  in_ready, out_valid, acc, flag_c, flag_z, flag_v, ovf_sticky
  );

  modport slave (
    input  in_valid, in_op, in_operand, out_ready,
    output in_ready, out_valid, acc, flag_c, flag_z, flag_v, ovf_sticky
  );

endinterface

// File: rtl/adder.sv
// N-bit adder with carry-in; carry output is carry-out XOR cin so that a
// subtract (cin=1, inverted B) reports borrow.
module adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] result,
  output logic         carry,
  output logic         zero,
  output logic         overflow
);

  logic [N:0] sum;

  always_comb begin
    sum      = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    result   = sum[N-1:0];
    carry    = sum[N] ^ cin;
    zero     = (sum[N-1:0] == '0);
    overflow = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
  end

endmodule

// File: rtl/acc_unit.sv
// Registered accumulator stage: one command per cycle in, one result per
// accept out through a single-entry output register with backpressure.
module acc_unit
  import acc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  acc_unit_if.slave   bus
);

  logic [N-1:0] acc_q, acc_d;
  logic         flag_c_q, flag_c_d;
  logic         flag_z_q, flag_z_d;
  logic         flag_v_q, flag_v_d;
  logic         sticky_q, sticky_d;
  logic         out_valid_q, out_valid_d;

  logic         in_ready;
  logic         accept;
  logic [N-1:0] add_b;
  logic         add_cin;
  logic [N-1:0] add_result;
  logic         add_carry;
  logic         add_zero;
  logic         add_overflow;

  adder #(.N(N)) u_adder (
    .a        (acc_q),
    .b        (add_b),
    .cin      (add_cin),
    .result   (add_result),
    .carry    (add_carry),
    .zero     (add_zero),
    .overflow (add_overflow)
  );

  always_comb begin
    in_ready = !out_valid_q || bus.out_ready;
    accept   = bus.in_valid && in_ready;
    add_cin  = (bus.in_op == OP_SUB);
    add_b    = add_cin ? ~bus.in_operand : bus.in_operand;
  end

  always_comb begin
    acc_d       = acc_q;
    flag_c_d    = flag_c_q;
    flag_z_d    = flag_z_q;
    flag_v_d    = flag_v_q;
    sticky_d    = sticky_q;
    out_valid_d = out_valid_q;

    if (accept) begin
      out_valid_d = 1'b1;
      case (bus.in_op)
        OP_ADD, OP_SUB: begin
          acc_d    = add_result;
          flag_c_d = add_carry;
          flag_z_d = add_zero;
          flag_v_d = add_overflow;
          sticky_d = sticky_q | add_overflow;
        end
        OP_LOAD: begin
          acc_d    = bus.in_operand;
          flag_c_d = 1'b0;
          flag_z_d = (bus.in_operand == '0);
          flag_v_d = 1'b0;
        end
        default: begin
          acc_d    = '0;
          flag_c_d = 1'b0;
          flag_z_d = 1'b1;
          flag_v_d = 1'b0;
          sticky_d = 1'b0;
        end
      endcase
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Reset wins over any same-edge accept or consume.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= N'(ACC_RST);
      flag_c_q    <= 1'b0;
      flag_z_q    <= FLAG_Z_RST;
      flag_v_q    <= 1'b0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      flag_c_q    <= flag_c_d;
      flag_z_q    <= flag_z_d;
      flag_v_q    <= flag_v_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.acc        = acc_q;
  assign bus.flag_c     = flag_c_q;
  assign bus.flag_z     = flag_z_q;
  assign bus.flag_v     = flag_v_q;
  assign bus.ovf_sticky = sticky_q;

endmodule

// File: tb/tb_acc_unit.sv
// Self-checking bench for acc_unit: directed scenarios plus randomized
// traffic compared against an integer-arithmetic reference model.
module tb_acc_unit;
  import acc_pkg::*;

  localparam int N   = 4;
  localparam int MOD = 1 << N;

  logic clk;
  logic rst_n;

  acc_unit_if #(.N(N)) bus ();

  acc_unit #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Reference model state.
  int   m_acc;
  logic m_c, m_z, m_v, m_st, m_ov;
  logic obs_ready, exp_ready;

  function automatic int sgn(input int x);
    return (x >= MOD / 2) ? x - MOD : x;
  endfunction

  function automatic logic [N+4:0] exp_vec();
    return {m_ov, N'(m_acc), m_c, m_z, m_v, m_st};
  endfunction

  function automatic logic [N+4:0] dut_vec();
    return {bus.out_valid, bus.acc, bus.flag_c, bus.flag_z, bus.flag_v, bus.ovf_sticky};
  endfunction

  task automatic model_reset();
    m_acc = 0; m_c = 0; m_z = 1; m_v = 0; m_st = 0; m_ov = 0;
  endtask

  task automatic model_exec(input acc_op_t op, input int b);
    int r;
    case (op)
      OP_ADD: begin
        r    = m_acc + b;
        m_c  = (r >= MOD);
        r    = r % MOD;
        m_v  = (sgn(m_acc) + sgn(b)) != sgn(r);
        m_st = m_st | m_v;
      end
      OP_SUB: begin
        m_c  = (m_acc < b);
        r    = (m_acc - b + MOD) % MOD;
        m_v  = (sgn(m_acc) - sgn(b)) != sgn(r);
        m_st = m_st | m_v;
      end
      OP_LOAD: begin
        r = b; m_c = 0; m_v = 0;
      end
      default: begin
        r = 0; m_c = 0; m_v = 0; m_st = 0;
      end
    endcase
    m_acc = r;
    m_z   = (r == 0);
  endtask

  // Drive one clock cycle and advance the model; leaves time at posedge+1.
  task automatic cycle(input logic v, input acc_op_t op, input logic [N-1:0] b,
                       input logic ordy, input logic rn);
    logic acc_ok;
    bus.in_valid   = v;
    bus.in_op      = op;
    bus.in_operand = b;
    bus.out_ready  = ordy;
    rst_n          = rn;
    #1;
    obs_ready = bus.in_ready;
    exp_ready = !m_ov || ordy;
    acc_ok    = v && exp_ready;
    @(posedge clk);
    if (!rn) begin
      model_reset();
    end else begin
      if (acc_ok) begin
        model_exec(op, int'(b));
        m_ov = 1'b1;
      end else if (m_ov && ordy) begin
        m_ov = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b0, OP_ADD, '0, 1'b0, 1'b0);
    cycle(1'b1, OP_LOAD, 4'h9, 1'b1, 1'b0);
    n_tests++;
    if (dut_vec() !== {1'b0, 4'h0, 4'b0100}) begin
      n_fail++;
      $display("FAIL reset_state: got %b required %b", dut_vec(), {1'b0, 4'h0, 4'b0100});
    end
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
    end
    $display("[TB] reset: out_valid=%b acc=%h", bus.out_valid, bus.acc);
  endtask

  typedef struct {
    acc_op_t    op;
    logic [3:0] operand;
    logic [3:0] acc;
    logic [3:0] czvs;
  } dir_t;

  task automatic test_directed();
    dir_t t [11];
    t[0]  = '{OP_LOAD, 4'h7, 4'h7, 4'b0000};
    t[1]  = '{OP_ADD,  4'h1, 4'h8, 4'b0011};
    t[2]  = '{OP_ADD,  4'h0, 4'h8, 4'b0001};
    t[3]  = '{OP_CLR,  4'h0, 4'h0, 4'b0100};
    t[4]  = '{OP_LOAD, 4'h3, 4'h3, 4'b0000};
    t[5]  = '{OP_SUB,  4'h5, 4'hE, 4'b1000};
    t[6]  = '{OP_LOAD, 4'h5, 4'h5, 4'b0000};
    t[7]  = '{OP_SUB,  4'h3, 4'h2, 4'b0000};
    t[8]  = '{OP_LOAD, 4'hF, 4'hF, 4'b0000};
    t[9]  = '{OP_ADD,  4'h1, 4'h0, 4'b1100};
    t[10] = '{OP_LOAD, 4'h0, 4'h0, 4'b0100};
    for (int i = 0; i < 11; i++) begin
      cycle(1'b1, t[i].op, t[i].operand, 1'b1, 1'b1);
      n_tests++;
      if (dut_vec() !== {1'b1, t[i].acc, t[i].czvs}) begin
        n_fail++;
        $display("FAIL directed_%0d: got %b required %b", i, dut_vec(), {1'b1, t[i].acc, t[i].czvs});
      end
      $display("[TB] directed %0d op=%s b=%h -> acc=%h czvs=%b", i, t[i].op.name(),
               t[i].operand, bus.acc, {bus.flag_c, bus.flag_z, bus.flag_v, bus.ovf_sticky});
    end
  endtask

  task automatic test_backpressure();
    logic [N+4:0] held;
    cycle(1'b1, OP_LOAD, 4'h1, 1'b1, 1'b1);
    cycle(1'b1, OP_ADD, 4'h2, 1'b1, 1'b1);
    held = dut_vec();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, OP_ADD, 4'h3, 1'b0, 1'b1);
      n_tests++;
      if (obs_ready !== 1'b0 || dut_vec() !== held) begin
        n_fail++;
        $display("FAIL stall_%0d: in_ready=%b state=%b required in_ready=0 state=%b",
                 i, obs_ready, dut_vec(), held);
      end
      $display("[TB] stall %0d: in_ready=%b acc=%h", i, obs_ready, bus.acc);
    end
    cycle(1'b1, OP_ADD, 4'h3, 1'b1, 1'b1);
    n_tests++;
    if (obs_ready !== 1'b1 || dut_vec() !== {1'b1, 4'h6, 4'b0000} || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL stall_release: in_ready=%b state=%b required in_ready=1 state=%b",
               obs_ready, dut_vec(), {1'b1, 4'h6, 4'b0000});
    end
    $display("[TB] release: acc=%h out_valid=%b", bus.acc, bus.out_valid);
    cycle(1'b0, OP_ADD, 4'h0, 1'b1, 1'b1);
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.acc !== 4'h6) begin
      n_fail++;
      $display("FAIL drain: out_valid=%b acc=%h required out_valid=0 acc=6", bus.out_valid, bus.acc);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, OP_CLR, 4'h0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, OP_ADD, 4'h1, 1'b1, 1'b1);
      n_tests++;
      if (obs_ready !== 1'b1 || dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL b2b_%0d: in_ready=%b state=%b required in_ready=1 state=%b",
                 i, obs_ready, dut_vec(), exp_vec());
      end
      if (i == 15) begin
        n_tests++;
        if (bus.acc !== 4'h0 || bus.flag_c !== 1'b1 || bus.flag_z !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_wrap: acc=%h c=%b z=%b required acc=0 c=1 z=1",
                   bus.acc, bus.flag_c, bus.flag_z);
        end
      end
      $display("[TB] b2b %0d: acc=%h c=%b", i, bus.acc, bus.flag_c);
    end
    n_tests++;
    if (bus.acc !== 4'h4) begin
      n_fail++;
      $display("FAIL b2b_final: acc=%h required 4", bus.acc);
    end
  endtask

  task automatic test_reset_stall();
    cycle(1'b1, OP_LOAD, 4'h5, 1'b1, 1'b1);
    cycle(1'b1, OP_ADD, 4'h2, 1'b0, 1'b1);
    cycle(1'b1, OP_ADD, 4'h2, 1'b0, 1'b0);
    n_tests++;
    if (dut_vec() !== {1'b0, 4'h0, 4'b0100} || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_stall: state=%b in_ready=%b required state=%b in_ready=1",
               dut_vec(), bus.in_ready, {1'b0, 4'h0, 4'b0100});
    end
    cycle(1'b0, OP_ADD, 4'h2, 1'b0, 1'b1);
    n_tests++;
    if (dut_vec() !== {1'b0, 4'h0, 4'b0100}) begin
      n_fail++;
      $display("FAIL reset_stall_after: state=%b required %b", dut_vec(), {1'b0, 4'h0, 4'b0100});
    end
    $display("[TB] reset during stall: out_valid=%b acc=%h", bus.out_valid, bus.acc);
  endtask

  task automatic test_random();
    logic       v, ordy;
    acc_op_t    op;
    logic [3:0] b;
    for (int i = 0; i < 300; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      op   = acc_op_t'($urandom_range(0, 3) == 3 ? (($urandom_range(0, 4) == 0) ? 3 : 0)
                                                 : $urandom_range(0, 2));
      b    = 4'($urandom_range(0, MOD - 1));
      cycle(v, op, b, ordy, 1'b1);
      n_tests++;
      if (obs_ready !== exp_ready || dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_%0d: in_ready=%b state=%b required in_ready=%b state=%b",
                 i, obs_ready, dut_vec(), exp_ready, exp_vec());
      end
      $display("[TB] random %0d v=%b op=%s b=%h ordy=%b -> ov=%b acc=%h", i, v, op.name(), b,
               ordy, bus.out_valid, bus.acc);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_reset();
    bus.in_valid   = 1'b0;
    bus.in_op      = OP_ADD;
    bus.in_operand = '0;
    bus.out_ready  = 1'b0;
    rst_n          = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_unit.md
# acc_unit

Registered accumulator stage for the N-bit integer datapath. Accepts a stream of {op, operand} commands over a valid/ready handshake and drives the shared `adder` with the accumulator and operand. It then captures `Result`/`Carry`/`Zero`/`Overflow` into architectural registers and presents each result downstream over a one-entry output handshake. Throughput is one command per cycle; backpressure propagates upstream.

## Interface
- `N`, 4: datapath width in bits (≥2).
- `clk` input 1: sole clock, all state on rising edge.
- `rst_n` input 1: synchronous active-low reset, sampled on `clk` rising edge.
- `in_valid` input 1: command present.
- `in_ready` output 1: stage can accept a command this cycle.
- `in_op` input 2: command; see `acc_pkg`.
- `in_operand` input N: operand B.
- `out_valid` output 1: `acc`/flags hold a new, unconsumed result.
- `out_ready` input 1: downstream consumes the result.
- `acc` output N: accumulator value.
- `flag_c` output 1: carry (ADD) / borrow (SUB).
- `flag_z` output 1: `acc` == 0.
- `flag_v` output 1: signed overflow of the last op.
- `ovf_sticky` output 1: OR of `flag_v` since the last CLR or reset.

## Operation
- Accept = `in_valid && in_ready`; `in_ready` = `!out_valid || out_ready` (combinational, no dependence on `in_valid`).
- Ops (on accept, all registered at the same edge):
  - ADD (2'b00): adder A=`acc`, B=`in_operand`, Cin=0. `acc`←Result; C/Z/V←adder flags.
  - SUB (2'b01): A=`acc`, B=~`in_operand`, Cin=1. `acc`←Result; C/Z/V←adder flags. C=1 means borrow (unsigned `acc` < operand), because the adder reports carry-out XOR Cin.
  - LOAD (2'b10): `acc`←`in_operand`; Z←(operand==0); C←0; V←0.
  - CLR (2'b11): `acc`←0; Z←1; C←0; V←0; `ovf_sticky`←0.
- `ovf_sticky` ← `ovf_sticky | new V` on ADD/SUB. CLR clears it.
- Width: all arithmetic is modulo 2^N. No saturation. Operands are treated as two's complement for V and as unsigned for C.
- `out_valid`: set on accept. Cleared when `out_valid && out_ready && !accept`. Stays 1 on simultaneous consume+accept.
- No accept: `acc`, flags and sticky hold their values, regardless of `out_ready`.
- Outputs are stable while `out_valid && !out_ready`.

## Timing
- Reset (`rst_n`=0 at an edge): `acc`=0, `flag_c`=0, `flag_z`=1, `flag_v`=0, `ovf_sticky`=0, `out_valid`=0. `in_ready`=1 from the first cycle after reset. Reset overrides a same-cycle accept or consume.
- Latency: a command accepted at edge k appears with `out_valid`=1 in cycle k+1.
- Back-to-back: with `out_ready` held 1, one command per cycle. Each op uses `acc` as updated by the previous accepted op (no hazard, no bubble).
- Stall: `out_valid`=1 and `out_ready`=0 force `in_ready`=0. No command is dropped or duplicated.
- Reset mid-stall: the pending result is discarded, with no output pulse after reset.
- `in_op`/`in_operand` are don't-care when `in_valid`=0.

## Structure
- `acc_pkg`: `typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_LOAD, OP_CLR} acc_op_t;` plus the reset constants (`ACC_RST`, `FLAG_Z_RST`).
- One sub-module: an instance of the existing `adder #(.N(N))`. Its B and Cin are muxed per op, and its flag outputs are used unmodified.
- The remainder is an output-holding register with `out_valid` control.

## Test plan
- Reset, then with N=4 and `out_ready`=1: LOAD 7, ADD 1 → `acc`=4'h8, C=0, Z=0, V=1, `ovf_sticky`=1. ADD 0 → V=0, `ovf_sticky` still 1. CLR → `acc`=0, Z=1, sticky=0.
- LOAD 3, SUB 5 → `acc`=4'hE, C=1 (borrow), V=0, Z=0. LOAD 5, SUB 3 → `acc`=2, C=0.
- LOAD 4'hF, ADD 1 → `acc`=0, C=1, Z=1, V=0. LOAD 0 → Z=1, C=0.
- Backpressure: accept ADD 2, hold `out_ready`=0 for 3 cycles → `in_ready`=0, `acc`/flags constant, the `in_valid` command is not consumed. Raise `out_ready` → the same cycle accepts the next command, and `out_valid` stays 1.
- Back-to-back ADD 1 ×20 from `acc`=0 with `out_ready`=1 → one result per cycle, `acc` wraps F→0 with C=1 at the 16th op, final `acc`=4.
- Assert `rst_n`=0 during a stall with `in_valid`=1 → next cycle `out_valid`=0, `acc`=0, Z=1, `in_ready`=1, and the command is not executed.
